// File: rtl/mem_pkg.sv
// Shared sizing constants and FSM state encoding for the external SRAM controller.
package mem_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned RAM_DEPTH  = 1024;
    localparam int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD     = 3'd2,
        RD_CAP = 3'd3,
        TURN   = 3'd4
    } state_e;

endpackage

// File: rtl/mem_ctrl.sv
// Single-port external SRAM controller: valid/ready request side, registered RAM strobes,
// one-cycle writes, 3-cycle reads with a bus turnaround cycle for read-then-write.
module mem_ctrl #(
    parameter int unsigned DATA_WIDTH = mem_pkg::DATA_WIDTH,
    parameter int unsigned RAM_DEPTH  = mem_pkg::RAM_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_ip,
    input  logic                  rst_ip,
    input  logic                  req_valid_ip,
    output logic                  req_ready_op,
    input  logic                  req_we_ip,
    input  logic [ADDR_WIDTH-1:0] req_addr_ip,
    input  logic [DATA_WIDTH-1:0] req_wdata_ip,
    output logic                  rsp_valid_op,
    output logic [DATA_WIDTH-1:0] rsp_rdata_op,
    output logic                  cs_op,
    output logic                  we_op,
    output logic                  oe_op,
    output logic [ADDR_WIDTH-1:0] address_op,
    output logic [DATA_WIDTH-1:0] data_op,
    output logic                  data_oe_op,
    input  logic [DATA_WIDTH-1:0] data_ip
);
    import mem_pkg::*;

    state_e                  state;
    state_e                  state_nxt;
    logic                    accept;
    logic                    from_pend;
    logic                    cs_d;
    logic                    we_d;
    logic                    oe_d;
    logic                    ready_d;
    logic                    rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic [ADDR_WIDTH-1:0]   pend_addr;
    logic [DATA_WIDTH-1:0]   pend_wdata;

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt   = state;
        accept      = req_valid_ip && req_ready_op;
        from_pend   = 1'b0;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        oe_d        = 1'b0;
        ready_d     = 1'b0;
        addr_d      = address_op;
        data_d      = data_op;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_op;

        unique case (state)
            IDLE, WR: begin
                if (accept) state_nxt = req_we_ip ? WR : RD;
                else        state_nxt = IDLE;
            end
            RD_CAP: begin
                // A write right behind a read needs a dead cycle while the RAM releases the bus.
                if (accept) state_nxt = req_we_ip ? TURN : RD;
                else        state_nxt = IDLE;
            end
            RD:      state_nxt = RD_CAP;
            TURN:    state_nxt = WR;
            default: state_nxt = IDLE;
        endcase

        from_pend = (state == TURN);
        cs_d      = (state_nxt == WR) || (state_nxt == RD);
        we_d      = (state_nxt == WR);
        oe_d      = (state_nxt == RD);
        ready_d   = (state_nxt == IDLE) || (state_nxt == WR) || (state_nxt == RD_CAP);

        // The RAM-side address/data only move when a new access begins; otherwise they hold.
        if (cs_d) addr_d = from_pend ? pend_addr : req_addr_ip;
        if (we_d) data_d = from_pend ? pend_wdata : req_wdata_ip;

        if (state == RD_CAP) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = data_ip;
        end
    end

    // State, pending request and output registers.
    always_ff @(posedge clk_ip) begin
        if (rst_ip) begin
            state        <= IDLE;
            req_ready_op <= 1'b0;
            rsp_valid_op <= 1'b0;
            rsp_rdata_op <= '0;
            cs_op        <= 1'b0;
            we_op        <= 1'b0;
            oe_op        <= 1'b0;
            data_oe_op   <= 1'b0;
            address_op   <= '0;
            data_op      <= '0;
            pend_addr    <= '0;
            pend_wdata   <= '0;
        end else begin
            state        <= state_nxt;
            req_ready_op <= ready_d;
            rsp_valid_op <= rsp_valid_d;
            rsp_rdata_op <= rsp_rdata_d;
            cs_op        <= cs_d;
            we_op        <= we_d;
            oe_op        <= oe_d;
            data_oe_op   <= we_d;
            address_op   <= addr_d;
            data_op      <= data_d;
            if (accept) begin
                pend_addr  <= req_addr_ip;
                pend_wdata <= req_wdata_ip;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural SRAM on the RAM-side pins, directed vector table,
// reset corner sequences and a random run checked by a response/write scoreboard.
module tb_mem_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;

    // Expected strobe vector {cs, we, oe, data_oe, ready}
    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_WR   = 5'b11011;
    localparam logic [4:0] S_RD   = 5'b10100;
    localparam logic [4:0] S_TURN = 5'b00000;

    logic          clk_ip = 1'b0;
    logic          rst_ip;
    logic          req_valid_ip;
    logic          req_ready_op;
    logic          req_we_ip;
    logic [AW-1:0] req_addr_ip;
    logic [DW-1:0] req_wdata_ip;
    logic          rsp_valid_op;
    logic [DW-1:0] rsp_rdata_op;
    logic          cs_op;
    logic          we_op;
    logic          oe_op;
    logic [AW-1:0] address_op;
    logic [DW-1:0] data_op;
    logic          data_oe_op;
    logic [DW-1:0] data_ip;

    int errors = 0;
    int checks = 0;

    mem_ctrl dut (
        .clk_ip       (clk_ip),
        .rst_ip       (rst_ip),
        .req_valid_ip (req_valid_ip),
        .req_ready_op (req_ready_op),
        .req_we_ip    (req_we_ip),
        .req_addr_ip  (req_addr_ip),
        .req_wdata_ip (req_wdata_ip),
        .rsp_valid_op (rsp_valid_op),
        .rsp_rdata_op (rsp_rdata_op),
        .cs_op        (cs_op),
        .we_op        (we_op),
        .oe_op        (oe_op),
        .address_op   (address_op),
        .data_op      (data_op),
        .data_oe_op   (data_oe_op),
        .data_ip      (data_ip)
    );

    always #5 clk_ip = ~clk_ip;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural synchronous SRAM; unwritten words read back as init_val(address).
    logic [DW-1:0]    ram [DEPTH];
    logic [DEPTH-1:0] ram_wr;
    logic [DW-1:0]    ram_q;

    always @(posedge clk_ip) begin
        if (rst_ip) ram_wr <= '0;
        if (cs_op && we_op) begin
            ram[address_op]    <= data_op;
            ram_wr[address_op] <= 1'b1;
        end
        if (cs_op && oe_op && !we_op)
            ram_q <= ram_wr[address_op] ? ram[address_op] : init_val(address_op);
    end
    assign data_ip = ram_q;

    // Scoreboard: reads push expected data/cycle, writes push expected RAM-side address/data.
    typedef struct { logic [DW-1:0] data; int cyc; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    rsp_t             rsp_q[$];
    wr_t              wr_q[$];
    logic [DW-1:0]    mdl [DEPTH];
    logic [DEPTH-1:0] mdl_wr;
    int               ncyc = 0;

    always @(negedge clk_ip) begin
        rsp_t r;
        wr_t  w;
        logic do_wr;
        ncyc++;
        do_wr = 1'b0;
        chk("we_oe_exclusive", 32'(we_op && oe_op), 32'd0);
        chk("data_oe_only_in_write", 32'(data_oe_op && !(cs_op && we_op)), 32'd0);
        if (rsp_valid_op) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_data", 32'(rsp_rdata_op), 32'(r.data));
                chk("rsp_latency", 32'(ncyc), 32'(r.cyc));
            end
        end
        if (cs_op && we_op) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", 32'd1, 32'd0);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", 32'(address_op), 32'(w.addr));
                chk("wr_data", 32'(data_op), 32'(w.data));
                do_wr = 1'b1;
            end
        end
        if (rst_ip) begin
            mdl_wr = '0;
            rsp_q.delete();
            wr_q.delete();
        end
        if (do_wr) begin
            mdl[w.addr]    = w.data;
            mdl_wr[w.addr] = 1'b1;
        end
        if (!rst_ip && req_valid_ip && req_ready_op) begin
            if (req_we_ip) begin
                w.addr = req_addr_ip;
                w.data = req_wdata_ip;
                wr_q.push_back(w);
            end else begin
                r.data = mdl_wr[req_addr_ip] ? mdl[req_addr_ip] : init_val(req_addr_ip);
                r.cyc  = ncyc + 3;
                rsp_q.push_back(r);
            end
        end
    end

    typedef struct {
        logic          vld;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [4:0]    st;
        logic          rsp;
        logic [DW-1:0] rd;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
    } vec_t;

    localparam int NV = 25;
    vec_t vt [NV];

    task automatic drive(input logic vld, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid_ip = vld;
        req_we_ip    = we;
        req_addr_ip  = a;
        req_wdata_ip = d;
    endtask

    task automatic step();
        @(posedge clk_ip);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_op), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_op), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata_op), 32'd0);
        chk({tag, "_strobes"}, 32'({cs_op, we_op, oe_op, data_oe_op}), 32'd0);
        chk({tag, "_address"}, 32'(address_op), 32'd0);
        chk({tag, "_data"}, 32'(data_op), 32'd0);
    endtask

    initial begin
        int acc;
        int budget;

        vt[0]  = '{1'b1, 1'b1, 10'h003, 8'hA5, S_WR,   1'b0, 8'h00, 10'h003, 8'hA5};
        vt[1]  = '{1'b1, 1'b0, 10'h003, 8'h00, S_RD,   1'b0, 8'h00, 10'h003, 8'hA5};
        vt[2]  = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b0, 8'h00, 10'h003, 8'hA5};
        vt[3]  = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b1, 8'hA5, 10'h003, 8'hA5};
        vt[4]  = '{1'b1, 1'b1, 10'h000, 8'h11, S_WR,   1'b0, 8'hA5, 10'h000, 8'h11};
        vt[5]  = '{1'b1, 1'b1, 10'h001, 8'h22, S_WR,   1'b0, 8'hA5, 10'h001, 8'h22};
        vt[6]  = '{1'b1, 1'b1, 10'h002, 8'h33, S_WR,   1'b0, 8'hA5, 10'h002, 8'h33};
        vt[7]  = '{1'b1, 1'b1, 10'h003, 8'h44, S_WR,   1'b0, 8'hA5, 10'h003, 8'h44};
        vt[8]  = '{1'b1, 1'b0, 10'h000, 8'h00, S_RD,   1'b0, 8'hA5, 10'h000, 8'h44};
        vt[9]  = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b0, 8'hA5, 10'h000, 8'h44};
        vt[10] = '{1'b1, 1'b0, 10'h001, 8'h00, S_RD,   1'b1, 8'h11, 10'h001, 8'h44};
        vt[11] = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b0, 8'h11, 10'h001, 8'h44};
        vt[12] = '{1'b1, 1'b0, 10'h002, 8'h00, S_RD,   1'b1, 8'h22, 10'h002, 8'h44};
        vt[13] = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b0, 8'h22, 10'h002, 8'h44};
        vt[14] = '{1'b1, 1'b0, 10'h003, 8'h00, S_RD,   1'b1, 8'h33, 10'h003, 8'h44};
        vt[15] = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b0, 8'h33, 10'h003, 8'h44};
        vt[16] = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b1, 8'h44, 10'h003, 8'h44};
        vt[17] = '{1'b1, 1'b0, 10'h3FF, 8'h00, S_RD,   1'b0, 8'h44, 10'h3FF, 8'h44};
        vt[18] = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b0, 8'h44, 10'h3FF, 8'h44};
        vt[19] = '{1'b1, 1'b1, 10'h3FF, 8'h5A, S_TURN, 1'b1, 8'hA3, 10'h3FF, 8'h44};
        vt[20] = '{1'b0, 1'b0, 10'h000, 8'h00, S_WR,   1'b0, 8'hA3, 10'h3FF, 8'h5A};
        vt[21] = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b0, 8'hA3, 10'h3FF, 8'h5A};
        vt[22] = '{1'b1, 1'b0, 10'h3FF, 8'h00, S_RD,   1'b0, 8'hA3, 10'h3FF, 8'h5A};
        vt[23] = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b0, 8'hA3, 10'h3FF, 8'h5A};
        vt[24] = '{1'b0, 1'b0, 10'h000, 8'h00, S_IDLE, 1'b1, 8'h5A, 10'h3FF, 8'h5A};

        rst_ip = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        repeat (3) step();
        chk_all_zero("reset");
        rst_ip = 1'b0;
        step();
        chk("ready_after_reset", 32'(req_ready_op), 32'd1);

        // Directed table: drive a row, then compare outputs one cycle later.
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].vld, vt[i].we, vt[i].addr, vt[i].wd);
            step();
            chk($sformatf("vec%0d_strobes", i),
                32'({cs_op, we_op, oe_op, data_oe_op, req_ready_op}), 32'(vt[i].st));
            chk($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid_op), 32'(vt[i].rsp));
            chk($sformatf("vec%0d_rsp_rdata", i), 32'(rsp_rdata_op), 32'(vt[i].rd));
            chk($sformatf("vec%0d_address", i), 32'(address_op), 32'(vt[i].ea));
            chk($sformatf("vec%0d_data", i), 32'(data_op), 32'(vt[i].ed));
        end

        // Reset during RD_CAP drops the read.
        drive(1'b1, 1'b0, 10'h010, 8'h00);
        step();
        chk("rdcap_rst_in_rd", 32'({cs_op, oe_op, req_ready_op}), 32'b110);
        drive(1'b0, 1'b0, '0, '0);
        step();
        rst_ip = 1'b1;
        step();
        chk_all_zero("rdcap_rst");
        rst_ip = 1'b0;
        step();
        chk("rdcap_rst_ready", 32'(req_ready_op), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rdcap_rst_no_rsp", 32'(rsp_valid_op), 32'd0);
            step();
        end

        // Reset during TURN drops the queued write; the old word must read back.
        drive(1'b1, 1'b0, 10'h020, 8'h00);
        step();
        drive(1'b0, 1'b0, '0, '0);
        step();
        drive(1'b1, 1'b1, 10'h020, 8'h77);
        step();
        chk("turn_strobes", 32'({cs_op, we_op, oe_op, data_oe_op, req_ready_op}), 32'(S_TURN));
        chk("turn_rsp", 32'({rsp_valid_op, rsp_rdata_op}), 32'({1'b1, 8'h7C}));
        rst_ip = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        step();
        chk_all_zero("turn_rst");
        rst_ip = 1'b0;
        step();
        chk("turn_rst_no_write", 32'({cs_op, we_op}), 32'd0);
        drive(1'b1, 1'b0, 10'h020, 8'h00);
        step();
        drive(1'b0, 1'b0, '0, '0);
        step();
        step();
        chk("turn_rst_readback", 32'({rsp_valid_op, rsp_rdata_op}), 32'({1'b1, 8'h7C}));

        // Random traffic, mostly on a small address window so reads hit earlier writes.
        acc = 0;
        budget = 0;
        while (acc < 10000 && budget < 60000) begin
            req_valid_ip = ($urandom_range(0, 3) != 0);
            req_we_ip    = 1'($urandom_range(0, 1));
            req_addr_ip  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                       : 10'($urandom_range(0, 31));
            req_wdata_ip = 8'($urandom);
            if (req_valid_ip && req_ready_op) acc++;
            step();
            budget++;
        end
        chk("random_accept_count", 32'(acc >= 10000), 32'd1);

        drive(1'b0, 1'b0, '0, '0);
        repeat (6) step();
        chk("drain_rsp_queue", 32'(rsp_q.size()), 32'd0);
        chk("drain_wr_queue", 32'(wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bus width in bits.
REQ-002 Parameter RAM_DEPTH, default 1024: number of RAM words.
REQ-003 Parameter ADDR_WIDTH, default clog2(RAM_DEPTH) = 10: address width in bits.
REQ-004 The ports SHALL be as follows (name, direction, width, meaning):
- clk_ip, in, 1: single clock; all logic is posedge.
- rst_ip, in, 1: reset, synchronous, active-high.
- req_valid_ip, in, 1: request valid.
- req_ready_op, out, 1: request ready.
- req_we_ip, in, 1: 1 = write, 0 = read.
- req_addr_ip, in, ADDR_WIDTH: request address.
- req_wdata_ip, in, DATA_WIDTH: write data.
- rsp_valid_op, out, 1: read data valid; one-cycle pulse; no backpressure.
- rsp_rdata_op, out, DATA_WIDTH: read data.
- cs_op, out, 1: RAM chip select.
- we_op, out, 1: RAM write enable.
- oe_op, out, 1: RAM output enable.
- address_op, out, ADDR_WIDTH: RAM address.
- data_op, out, DATA_WIDTH: RAM write data.
- data_oe_op, out, 1: drive enable for the external tristate data bus.
- data_ip, in, DATA_WIDTH: RAM read data.

Function
REQ-005 A request SHALL be accepted on a posedge where req_valid_ip and req_ready_op are both 1; otherwise it is ignored.
REQ-006 The FSM SHALL have exactly these states: IDLE, WR, RD, RD_CAP, TURN.
REQ-007 req_ready_op SHALL be 1 in IDLE, WR and RD_CAP, and 0 in RD, TURN and during reset.
REQ-008 Transitions on acceptance:
- A write from IDLE or WR goes to WR.
- A write from RD_CAP goes to TURN, then to WR.
- A read from IDLE, WR or RD_CAP goes to RD.
REQ-009 Fixed transitions: RD always goes to RD_CAP. With no acceptance, WR and RD_CAP go to IDLE.
REQ-010 In WR the outputs SHALL be: cs_op=1, we_op=1, oe_op=0, data_oe_op=1, with address_op and data_op taken from the registered request. Each write occupies exactly one cycle.
REQ-011 In RD the outputs SHALL be: cs_op=1, we_op=0, oe_op=1, data_oe_op=0. The RAM returns data_ip during the following cycle (RD_CAP).
REQ-012 data_ip SHALL be registered at the posedge ending RD_CAP. rsp_valid_op pulses for the next single cycle with rsp_rdata_op holding that data.
REQ-013 Read latency SHALL be exactly 3 cycles: accepted at edge N, rsp_valid_op=1 in cycle N+3. Back-to-back reads give one response every 2 cycles.
REQ-014 In IDLE, RD_CAP and TURN the strobes SHALL be cs_op=we_op=oe_op=data_oe_op=0.
REQ-015 we_op and oe_op SHALL never both be 1. data_oe_op SHALL be 1 only in WR.
REQ-016 address_op and data_op SHALL hold their last value when not in WR or RD, and SHALL be stable throughout each WR and RD cycle.
REQ-017 rsp_rdata_op SHALL hold its value between pulses.
REQ-018 A write accepted in the cycle that rsp_valid_op is high SHALL NOT corrupt or delay that response.

Reset
REQ-019 While rst_ip=1 at a posedge, the next state SHALL be IDLE with all outputs 0, including rsp_valid_op, rsp_rdata_op, address_op and data_op.
REQ-020 Reset asserted mid-read SHALL discard the read: no rsp_valid_op pulse afterwards.
REQ-021 Reset asserted mid-TURN SHALL discard the pending write.
REQ-022 req_ready_op SHALL be 1 in the first cycle after rst_ip deasserts.

Structure
REQ-023 Package mem_pkg SHALL hold DATA_WIDTH, RAM_DEPTH, ADDR_WIDTH and the FSM state enum type.
REQ-024 The block SHALL be flat with no sub-module. Request, address and data registers and the FSM live in mem_ctrl.
REQ-025 The bench SHALL bind a RAM model with ports clk_ip, we_ip, address_ip, data_ip, cs_ip and oe_ip, plus a scoreboard, to the RAM-side outputs.

Verification
REQ-026 Write 0xA5 to address 0x003, then read 0x003 -> WR one cycle, TURN absent, rsp_valid_op=1 exactly 3 cycles after read acceptance, rsp_rdata_op=0xA5.
REQ-027 Read 0x3FF, then immediately write 0x5A to 0x3FF, accepted in RD_CAP -> one TURN cycle with all strobes 0, then WR; the read returns the old value.
REQ-028 Four back-to-back writes to addresses 0x000-0x003 with data 0x11-0x44 -> four consecutive WR cycles, req_ready_op held 1, readback matches.
REQ-029 Read 0x010 with rst_ip=1 in RD_CAP -> no rsp_valid_op, all outputs 0, req_ready_op=1 the cycle after reset deasserts.
REQ-030 Random 10,000 requests -> scoreboard matches every response; we_op and oe_op never both 1; data_oe_op=1 only with we_op=1.
